// File: rtl/seg_scan_driver.sv
// seg_scan_driver: four-digit seven-segment scan driver with frame-boundary loading; optional digit blink under SEG_BLINK_EN
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blink_mask,
    output logic [1:0]  en,
    output logic [3:0]  digit,
    output logic        blank,
    output logic        frame_start,
    output logic        pending
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc;
    logic [15:0]   disp, pend, disp_n;
    logic [1:0]    en_n;
    logic [3:0]    nib_n;
    logic          step, bnd, blink_n;

    // next-state view so digit/blank register together with en
    always_comb begin
        step   = presc == PMAX;
        bnd    = step && en == 2'd3;
        en_n   = step ? en + 2'd1 : en;
        disp_n = bnd ? (load ? digits_in : (pending ? pend : disp)) : disp;
        nib_n  = en_n == 2'd0 ? disp_n[15:12] :
                 en_n == 2'd1 ? disp_n[11:8]  :
                 en_n == 2'd2 ? disp_n[7:4]   : disp_n[3:0];
    end

`ifdef SEG_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

    logic [BW-1:0] bcnt;
    logic          phase, phase_n;

    assign phase_n = bcnt == BMAX ? ~phase : phase;
    assign blink_n = phase_n & blink_mask[~en_n];

    // free-running blink half-period counter, independent of the scan
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            bcnt  <= bcnt == BMAX ? '0 : bcnt + 1'b1;
            phase <= phase_n;
        end
    end
`else
    logic unused_mask;

    assign unused_mask = ^blink_mask;
    assign blink_n     = 1'b0;
`endif

    // prescaler, digit select, frame buffering and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            en          <= 2'd0;
            disp        <= '0;
            pend        <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
            digit       <= 4'd0;
            blank       <= 1'b0;
        end else begin
            presc       <= step ? '0 : presc + 1'b1;
            en          <= en_n;
            disp        <= disp_n;
            pend        <= load && !bnd ? digits_in : pend;
            pending     <= !bnd && (load || pending);
            frame_start <= bnd;
            digit       <= nib_n;
            blank       <= (nib_n > 4'd9) | blink_n;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver (REFRESH_DIV=4, BLINK_DIV=8)
module tb_seg_scan_driver;
    localparam int RD = 4;
    localparam int BD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  blink_mask = '0;
    logic [1:0]  en;
    logic [3:0]  digit;
    logic        blank, frame_start, pending;

    int vectors = 0;
    int miscompares = 0;
    int k = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .blink_mask(blink_mask),
        .en(en), .digit(digit), .blank(blank), .frame_start(frame_start), .pending(pending)
    );

    task automatic do_reset(input logic ld, input logic [15:0] d);
        rst = 1'b1;
        load = ld;
        digits_in = d;
        @(posedge clk);
        #1;
        rst = 1'b0;
        load = 1'b0;
        k = 0;
    endtask

    task automatic tick(input string name, input logic ld, input logic [15:0] d,
                        input logic [15:0] frame, input logic pend);
        logic [1:0] e;
        logic [3:0] n;
        logic       b;
        logic [8:0] exp, got;
        e = 2'((k / RD) % 4);
        n = frame[(3 - int'(e)) * 4 +: 4];
        b = n > 4'd9;
`ifdef SEG_BLINK_EN
        b = b | (((k / BD) % 2 == 1) && blink_mask[3 - int'(e)]);
`endif
        sb.push_back({e, n, b, (k != 0 && k % (4 * RD) == 0), pend});
        load = ld;
        digits_in = d;
        got = {en, digit, blank, frame_start, pending};
        exp = sb.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d en/digit/blank/fs/pending got %b/%h/%b/%b/%b want %b/%h/%b/%b/%b",
                     name, k, got[8:7], got[6:3], got[2], got[1], got[0],
                     exp[8:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        k++;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 16'h1234);
        for (int i = 0; i < 18; i++) tick("reset", 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic test_idle();
        do_reset(1'b0, 16'h0);
        for (int i = 0; i <= 32; i++) tick("idle", 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic test_pending();
        do_reset(1'b0, 16'h0);
        for (int i = 0; i <= 32; i++)
            tick("pending", i == 5, 16'h1234, i >= 16 ? 16'h1234 : 16'h0, i >= 6 && i < 16);
    endtask

    task automatic test_last_wins();
        do_reset(1'b0, 16'h0);
        for (int i = 0; i <= 32; i++)
            tick("last_wins", i == 3 || i == 9, i == 3 ? 16'h1111 : 16'h5959,
                 i >= 16 ? 16'h5959 : 16'h0, i >= 4 && i < 16);
    endtask

    task automatic test_boundary_load();
        do_reset(1'b0, 16'h0);
        for (int i = 0; i <= 32; i++)
            tick("boundary_load", i == 10 || i == 15, i == 10 ? 16'h7777 : 16'h0808,
                 i >= 16 ? 16'h0808 : 16'h0, i >= 11 && i < 16);
    endtask

    task automatic test_blank_nibbles();
        do_reset(1'b0, 16'h0);
        for (int i = 0; i <= 32; i++)
            tick("blank_nibbles", i == 2, 16'hA1F2, i >= 16 ? 16'hA1F2 : 16'h0, i >= 3 && i < 16);
    endtask

    task automatic test_back_to_back();
        blink_mask = 4'hF;
        do_reset(1'b0, 16'h0);
        for (int i = 0; i <= 40; i++)
            tick("back_to_back", i == 5 || i == 20, i == 5 ? 16'h1234 : 16'h5678,
                 i >= 32 ? 16'h5678 : (i >= 16 ? 16'h1234 : 16'h0),
                 (i >= 6 && i < 16) || (i >= 21 && i < 32));
        blink_mask = 4'h0;
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink();
        blink_mask = 4'b1100;
        do_reset(1'b0, 16'h0);
        for (int i = 0; i < 20; i++)
            tick("blink_hi", i == 0, 16'h1200, i >= 16 ? 16'h1200 : 16'h0, i >= 1 && i < 16);
        do_reset(1'b0, 16'h0);
        tick("blink_reset", 1'b0, 16'h0, 16'h0, 1'b0);
        blink_mask = 4'b0011;
        do_reset(1'b0, 16'h0);
        for (int i = 0; i <= 32; i++)
            tick("blink_lo", i == 0, 16'h1200, i >= 16 ? 16'h1200 : 16'h0, i >= 1 && i < 16);
        blink_mask = 4'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_pending();
        test_last_wins();
        test_boundary_load();
        test_blank_nibbles();
        test_back_to_back();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan driver for the four-digit seven-segment display in the alarm clock. Holds a 4-digit BCD frame, steps the digit select at a fixed refresh rate, and presents digit select plus the matching BCD nibble to the segment decoder (`en`/`in` side). New frames are loaded through a strobe and applied only at a frame boundary, so the display never shows a mix of old and new digits. Sits between the timekeeping/alarm-set logic and the segment decoder.

## Interface
- `REFRESH_DIV`, 100000: clock cycles each digit is held (1 kHz per digit at 100 MHz); legal range ≥ 2.
- `BLINK_DIV`, 25000000: clock cycles per blink half-period (only used with `SEG_BLINK_EN`); legal range ≥ 1.

- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle strobe; captures `digits_in`.
- `digits_in`  in  16  `{d3,d2,d1,d0}`; d3 = leftmost digit.
- `blink_mask`  in  4  bit i set = digit di blinks; ignored without `SEG_BLINK_EN`.
- `en`  out  2  digit select to decoder; 00 = leftmost (d3) … 11 = rightmost (d0).
- `digit`  out  4  BCD nibble of the selected digit.
- `blank`  out  1  selected digit must be dark; the top level gates anodes with it.
- `frame_start`  out  1  one-cycle pulse when `en` wraps 11→00.
- `pending`  out  1  a loaded frame is waiting for the next boundary.

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. The terminal-count cycle is the step cycle: `en` increments mod 4 on the following edge.
- Display register: 16 bits. `digit` = display nibble selected by `en` (en=00→[15:12], 01→[11:8], 10→[7:4], 11→[3:0]). All outputs are registered; `en` and `digit` change on the same edge.
- Boundary = step cycle with `en`=11. On the edge ending it, `en`→00 and `frame_start`=1 for exactly one cycle.
- Load handling:
  - `load` outside a boundary cycle: `digits_in` → pending register and `pending`=1. The last load before the boundary wins.
  - At the boundary edge, if `pending`=1, pending → display register and `pending`=0.
  - `load` in the boundary cycle: `digits_in` goes directly to the display register; `pending`=0 and any older pending data is discarded.
- `blank`=1 when the selected nibble is greater than 9, because the decoder defines only 0–9. `digit` still carries the raw nibble.
- Reset, synchronous and dominant over `load`:
  - `en`=00, `digit`=0, `blank`=0, `frame_start`=0, `pending`=0.
  - Display and pending registers = 0; prescaler = 0; blink phase = 0.
  - Reset mid-frame abandons the frame and drops any pending data.

## Timing
- After reset is released, `en` is 00 for REFRESH_DIV cycles, then steps every REFRESH_DIV cycles. The frame period is 4·REFRESH_DIV cycles.
- Load-to-display latency is 1 to 4·REFRESH_DIV cycles: new digits first appear with `en`=00 on the boundary edge.
- `frame_start` is asserted in the same cycle that `en` first reads 00 of a new frame.

## Configuration
- `SEG_BLINK_EN` defined:
  - A blink phase bit toggles every BLINK_DIV cycles.
  - While phase=1 and `blink_mask` bit i is set, `blank`=1 whenever digit di is selected (mask[3]↔en=00 … mask[0]↔en=11).
  - Blanking ORs with the >9 blanking. The blink counter resets to 0 and runs independently of the scan.
- `SEG_BLINK_EN` undefined: no blink counter or phase logic; `blink_mask` unused; `blank` depends only on the >9 condition.

## Test plan
Parameters for all tests: REFRESH_DIV=4, BLINK_DIV=8.
- Reset then idle 32 cycles -> `en` sequence 00×4, 01×4, 10×4, 11×4 repeating; `digit`=0, `blank`=0; `frame_start` pulses at cycles 16 and 32.
- `load` `digits_in`=16'h1234 at cycle 5 -> `pending`=1 until cycle 16. From cycle 16: `digit` reads 1,2,3,4 for en=00,01,10,11; then `pending`=0.
- Loads 16'h1111 at cycle 3 and 16'h5959 at cycle 9 -> frame from cycle 16 shows 5,9,5,9; 1111 is never displayed.
- `load` 16'h0808 in the boundary cycle (cycle 15) with 16'h7777 pending -> 0,8,0,8 from cycle 16; `pending`=0; 7777 never displayed.
- Load 16'hA1F2 -> `blank`=1 for en=00 and en=10 with `digit`=A and F respectively; `blank`=0 for the 1 and 2 digits.
- With `SEG_BLINK_EN`: load 16'h1200, `blink_mask`=4'b1100 -> d3/d2 blanked during phase=1 (cycles 8–15, 24–31), visible otherwise; d1/d0 never blanked. Assert `rst` at cycle 20 -> next cycle all outputs at reset values, display 0.
